// File: rtl/stack_alu.sv
// WIDTH-bit stack-machine ALU: DEPTH-entry operand stack (entry 0 is TOS), valid/ready
// command port, and a WIDTH-cycle shift-add multiplier. Entries above the depth are kept at zero.
module stack_alu #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 opcode,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       carry,
    output logic                       zero,
    output logic                       error
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_PUSH = 4'h1;
    localparam logic [3:0] OP_POP  = 4'h2;
    localparam logic [3:0] OP_DUP  = 4'h3;
    localparam logic [3:0] OP_SWAP = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_NOT  = 4'hA;
    localparam logic [3:0] OP_SHL  = 4'hB;
    localparam logic [3:0] OP_SHR  = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hD;
    localparam logic [3:0] OP_CLR  = 4'hE;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;
    typedef enum logic [2:0] {
        ACT_NONE  = 3'd0,
        ACT_PUSH  = 3'd1,
        ACT_POP   = 3'd2,
        ACT_BIN   = 3'd3,
        ACT_UNARY = 3'd4,
        ACT_SWAP  = 3'd5,
        ACT_CLR   = 3'd6
    } act_t;

    state_t               state_r, state_s;
    act_t                 act_s;
    logic [WIDTH-1:0]     stack_r [DEPTH];
    logic [WIDTH-1:0]     stack_s [DEPTH];
    logic [DW-1:0]        depth_r, depth_s;
    logic                 carry_r, carry_s;
    logic                 error_r, error_s;
    logic                 in_ready_r;
    logic [2*WIDTH-1:0]   mcand_r, mcand_s;
    logic [WIDTH-1:0]     mplier_r, mplier_s;
    logic [2*WIDTH-1:0]   acc_r, acc_s;
    logic [CW-1:0]        cnt_r, cnt_s;
    logic [WIDTH-1:0]     res_s;
    logic [WIDTH-1:0]     a_s, b_s;
    logic [WIDTH:0]       sum_s, diff_s;
    logic [2*WIDTH-1:0]   step_s;
    logic                 need1_s, need2_s, not_full_s;

    assign a_s        = stack_r[0];
    assign b_s        = stack_r[1];
    assign sum_s      = {1'b0, b_s} + {1'b0, a_s};
    assign diff_s     = {1'b0, b_s} - {1'b0, a_s};
    assign step_s     = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
    assign need1_s    = (depth_r != {DW{1'b0}});
    assign need2_s    = (depth_r >= DW'(2));
    assign not_full_s = (depth_r < DEPTH_MAX);

    assign data_out = stack_r[0];
    assign depth    = depth_r;
    assign carry    = carry_r;
    assign error    = error_r;
    assign in_ready = in_ready_r;
    assign zero     = (data_out == {WIDTH{1'b0}});

    // Command decode, multiplier stepping and stack update.
    always_comb begin
        state_s  = state_r;
        act_s    = ACT_NONE;
        res_s    = {WIDTH{1'b0}};
        stack_s  = stack_r;
        depth_s  = depth_r;
        carry_s  = carry_r;
        error_s  = error_r;
        mcand_s  = mcand_r;
        mplier_s = mplier_r;
        acc_s    = acc_r;
        cnt_s    = cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    case (opcode)
                        OP_NOP: act_s = ACT_NONE;
                        OP_PUSH: begin
                            if (not_full_s) begin
                                act_s = ACT_PUSH;
                                res_s = data_in;
                            end else begin
                                error_s = 1'b1;
                            end
                        end
                        OP_POP: begin
                            if (need1_s) act_s = ACT_POP;
                            else error_s = 1'b1;
                        end
                        OP_DUP: begin
                            if (need1_s && not_full_s) begin
                                act_s = ACT_PUSH;
                                res_s = a_s;
                            end else begin
                                error_s = 1'b1;
                            end
                        end
                        OP_SWAP: begin
                            if (need2_s) act_s = ACT_SWAP;
                            else error_s = 1'b1;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            if (need2_s) begin
                                act_s = ACT_BIN;
                                case (opcode)
                                    OP_ADD: begin res_s = sum_s[WIDTH-1:0];  carry_s = sum_s[WIDTH];  end
                                    OP_SUB: begin res_s = diff_s[WIDTH-1:0]; carry_s = diff_s[WIDTH]; end
                                    OP_AND: begin res_s = b_s & a_s; carry_s = 1'b0; end
                                    OP_OR:  begin res_s = b_s | a_s; carry_s = 1'b0; end
                                    default: begin res_s = b_s ^ a_s; carry_s = 1'b0; end
                                endcase
                            end else begin
                                error_s = 1'b1;
                            end
                        end
                        OP_NOT, OP_SHL, OP_SHR: begin
                            if (need1_s) begin
                                act_s = ACT_UNARY;
                                case (opcode)
                                    OP_NOT: begin res_s = ~a_s; carry_s = 1'b0; end
                                    OP_SHL: begin res_s = {a_s[WIDTH-2:0], 1'b0}; carry_s = a_s[WIDTH-1]; end
                                    default: begin res_s = {1'b0, a_s[WIDTH-1:1]}; carry_s = a_s[0]; end
                                endcase
                            end else begin
                                error_s = 1'b1;
                            end
                        end
                        OP_MUL: begin
                            if (need2_s) begin
                                state_s  = ST_MUL;
                                mcand_s  = {{WIDTH{1'b0}}, a_s};
                                mplier_s = b_s;
                                acc_s    = {(2*WIDTH){1'b0}};
                                cnt_s    = {CW{1'b0}};
                            end else begin
                                error_s = 1'b1;
                            end
                        end
                        OP_CLR: begin
                            act_s   = ACT_CLR;
                            carry_s = 1'b0;
                            error_s = 1'b0;
                        end
                        default: act_s = ACT_NONE;
                    endcase
                end else begin
                    act_s = ACT_NONE;
                end
            end
            ST_MUL: begin
                acc_s    = step_s;
                mcand_s  = mcand_r << 1;
                mplier_s = mplier_r >> 1;
                cnt_s    = cnt_r + CW'(1);
                // The final step's sum is written straight back, so the result lands on the WIDTH-th edge.
                if (cnt_r == LAST_STEP) begin
                    state_s = ST_IDLE;
                    act_s   = ACT_BIN;
                    res_s   = step_s[WIDTH-1:0];
                    carry_s = |step_s[2*WIDTH-1:WIDTH];
                end else begin
                    state_s = ST_MUL;
                end
            end
            default: state_s = ST_IDLE;
        endcase

        case (act_s)
            ACT_PUSH: begin
                for (int i = DEPTH - 1; i > 0; i--) stack_s[i] = stack_r[i-1];
                stack_s[0] = res_s;
                depth_s    = depth_r + DW'(1);
            end
            ACT_POP, ACT_BIN: begin
                for (int i = 0; i < DEPTH - 1; i++) stack_s[i] = stack_r[i+1];
                stack_s[DEPTH-1] = {WIDTH{1'b0}};
                depth_s          = depth_r - DW'(1);
                if (act_s == ACT_BIN) stack_s[0] = res_s;
                else stack_s[0] = stack_r[1];
            end
            ACT_UNARY: stack_s[0] = res_s;
            ACT_SWAP: begin
                stack_s[0] = stack_r[1];
                stack_s[1] = stack_r[0];
            end
            ACT_CLR: begin
                for (int i = 0; i < DEPTH; i++) stack_s[i] = {WIDTH{1'b0}};
                depth_s = {DW{1'b0}};
            end
            default: stack_s = stack_r;
        endcase
    end

    // State, stack and flag registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            for (int i = 0; i < DEPTH; i++) stack_r[i] <= {WIDTH{1'b0}};
            depth_r    <= {DW{1'b0}};
            carry_r    <= 1'b0;
            error_r    <= 1'b0;
            in_ready_r <= 1'b1;
            mcand_r    <= {(2*WIDTH){1'b0}};
            mplier_r   <= {WIDTH{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            cnt_r      <= {CW{1'b0}};
        end else begin
            state_r    <= state_s;
            stack_r    <= stack_s;
            depth_r    <= depth_s;
            carry_r    <= carry_s;
            error_r    <= error_s;
            in_ready_r <= (state_s == ST_IDLE);
            mcand_r    <= mcand_s;
            mplier_r   <= mplier_s;
            acc_r      <= acc_s;
            cnt_r      <= cnt_s;
        end
    end
endmodule

// File: tb/tb_stack_alu.sv
// Directed bench for stack_alu: an 8-bit/4-deep instance driven from a vector table plus
// multiply/reset sequences, and a 16-bit/8-deep instance for the wide multiply.
module tb_stack_alu;
    localparam logic [3:0] NOP = 4'h0, PUSH = 4'h1, POP = 4'h2, DUP = 4'h3, SWAP = 4'h4;
    localparam logic [3:0] ADD = 4'h5, SUB = 4'h6, AND_ = 4'h7, OR_ = 4'h8, XOR_ = 4'h9;
    localparam logic [3:0] NOT_ = 4'hA, SHL = 4'hB, SHR = 4'hC, MUL = 4'hD, CLR = 4'hE, RSV = 4'hF;

    typedef struct {
        logic [3:0] op;
        logic [7:0] din;
        logic [7:0] q;
        logic [2:0] dep;
        logic       c;
        logic       e;
    } vec_t;

    logic        clk, rst;
    logic        in_valid, in_ready, carry, zero, error;
    logic [3:0]  opcode;
    logic [7:0]  data_in, data_out;
    logic [2:0]  depth;
    logic        w_in_valid, w_in_ready, w_carry, w_zero, w_error;
    logic [3:0]  w_opcode;
    logic [15:0] w_data_in, w_data_out;
    logic [3:0]  w_depth;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    int   busy;

    stack_alu #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
        .data_in(data_in), .data_out(data_out), .depth(depth), .carry(carry), .zero(zero),
        .error(error)
    );

    stack_alu #(.WIDTH(16), .DEPTH(8)) dut_w (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .opcode(w_opcode),
        .data_in(w_data_in), .data_out(w_data_out), .depth(w_depth), .carry(w_carry),
        .zero(w_zero), .error(w_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] op, input logic [7:0] din, input logic [7:0] q,
                           input logic [2:0] dep, input logic c, input logic e);
        vec_t v;
        v.op = op; v.din = din; v.q = q; v.dep = dep; v.c = c; v.e = e;
        vecs.push_back(v);
    endtask

    task automatic do_cmd(input logic [3:0] op, input logic [7:0] din);
        int n;
        @(negedge clk);
        in_valid = 1'b1; opcode = op; data_in = din;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("cmd ready timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic do_cmd_w(input logic [3:0] op, input logic [15:0] din);
        @(negedge clk);
        w_in_valid = 1'b1; w_opcode = op; w_data_in = din;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " data_out"}, 32'(data_out), 32'h0);
        check({tag, " depth"}, 32'(depth), 32'd0);
        check({tag, " carry"}, 32'(carry), 32'd0);
        check({tag, " error"}, 32'(error), 32'd0);
        check({tag, " zero"}, 32'(zero), 32'd1);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; opcode = 4'h0; data_in = 8'h00;
        w_in_valid = 1'b0; w_opcode = 4'h0; w_data_in = 16'h0000;

        //        op    din    q      dep   c     e
        add_vec(PUSH, 8'hF0, 8'hF0, 3'd1, 1'b0, 1'b0);
        add_vec(PUSH, 8'h20, 8'h20, 3'd2, 1'b0, 1'b0);
        add_vec(ADD,  8'h00, 8'h10, 3'd1, 1'b1, 1'b0);
        add_vec(POP,  8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
        add_vec(PUSH, 8'h03, 8'h03, 3'd1, 1'b1, 1'b0);
        add_vec(PUSH, 8'h05, 8'h05, 3'd2, 1'b1, 1'b0);
        add_vec(SUB,  8'h00, 8'hFE, 3'd1, 1'b1, 1'b0);
        add_vec(SHR,  8'h00, 8'h7F, 3'd1, 1'b0, 1'b0);
        add_vec(SHL,  8'h00, 8'hFE, 3'd1, 1'b0, 1'b0);
        add_vec(SHL,  8'h00, 8'hFC, 3'd1, 1'b1, 1'b0);
        add_vec(NOT_, 8'h00, 8'h03, 3'd1, 1'b0, 1'b0);
        add_vec(DUP,  8'h00, 8'h03, 3'd2, 1'b0, 1'b0);
        add_vec(PUSH, 8'h5A, 8'h5A, 3'd3, 1'b0, 1'b0);
        add_vec(XOR_, 8'h00, 8'h59, 3'd2, 1'b0, 1'b0);
        add_vec(SWAP, 8'h00, 8'h03, 3'd2, 1'b0, 1'b0);
        add_vec(AND_, 8'h00, 8'h01, 3'd1, 1'b0, 1'b0);
        add_vec(PUSH, 8'h80, 8'h80, 3'd2, 1'b0, 1'b0);
        add_vec(OR_,  8'h00, 8'h81, 3'd1, 1'b0, 1'b0);
        add_vec(NOP,  8'h77, 8'h81, 3'd1, 1'b0, 1'b0);
        add_vec(RSV,  8'h77, 8'h81, 3'd1, 1'b0, 1'b0);
        add_vec(POP,  8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        add_vec(POP,  8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        add_vec(PUSH, 8'h11, 8'h11, 3'd1, 1'b0, 1'b1);
        add_vec(CLR,  8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        add_vec(PUSH, 8'h01, 8'h01, 3'd1, 1'b0, 1'b0);
        add_vec(PUSH, 8'h02, 8'h02, 3'd2, 1'b0, 1'b0);
        add_vec(PUSH, 8'h03, 8'h03, 3'd3, 1'b0, 1'b0);
        add_vec(PUSH, 8'h04, 8'h04, 3'd4, 1'b0, 1'b0);
        add_vec(PUSH, 8'h05, 8'h04, 3'd4, 1'b0, 1'b1);
        add_vec(DUP,  8'h00, 8'h04, 3'd4, 1'b0, 1'b1);
        add_vec(CLR,  8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        add_vec(PUSH, 8'h07, 8'h07, 3'd1, 1'b0, 1'b0);
        add_vec(ADD,  8'h00, 8'h07, 3'd1, 1'b0, 1'b1);
        add_vec(CLR,  8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        add_vec(PUSH, 8'h09, 8'h09, 3'd1, 1'b0, 1'b0);
        add_vec(PUSH, 8'h04, 8'h04, 3'd2, 1'b0, 1'b0);
        add_vec(SUB,  8'h00, 8'h05, 3'd1, 1'b0, 1'b0);
        add_vec(MUL,  8'h00, 8'h05, 3'd1, 1'b0, 1'b1);
        add_vec(CLR,  8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check_reset_state("in reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_state("after reset");

        foreach (vecs[i]) begin
            do_cmd(vecs[i].op, vecs[i].din);
            check($sformatf("v%0d data_out", i), 32'(data_out), 32'(vecs[i].q));
            check($sformatf("v%0d depth", i), 32'(depth), 32'(vecs[i].dep));
            check($sformatf("v%0d carry", i), 32'(carry), 32'(vecs[i].c));
            check($sformatf("v%0d error", i), 32'(error), 32'(vecs[i].e));
            check($sformatf("v%0d zero", i), 32'(zero), 32'(vecs[i].q == 8'h00));
        end

        // 0x0C * 0x15, with a PUSH held on the port while busy that must be ignored
        do_cmd(PUSH, 8'h0C);
        do_cmd(PUSH, 8'h15);
        @(negedge clk);
        in_valid = 1'b1; opcode = MUL; data_in = 8'h00;
        @(posedge clk); #1;
        opcode = PUSH; data_in = 8'hAA;
        check("mul busy data_out", 32'(data_out), 32'h15);
        check("mul busy depth", 32'(depth), 32'd2);
        busy = 0;
        while (!in_ready && busy < 100) begin
            @(posedge clk); #1;
            busy++;
        end
        in_valid = 1'b0;
        check("mul busy cycles", 32'(busy), 32'd8);
        check("mul data_out", 32'(data_out), 32'hFC);
        check("mul carry", 32'(carry), 32'd0);
        check("mul depth", 32'(depth), 32'd1);
        check("mul error", 32'(error), 32'd0);
        @(posedge clk); #1;
        check("mul held push ignored", 32'(depth), 32'd1);

        // reset during the fourth multiply cycle
        do_cmd(PUSH, 8'h02);
        do_cmd(PUSH, 8'h03);
        @(negedge clk);
        in_valid = 1'b1; opcode = MUL;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid-mul in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check_reset_state("mid-mul reset");
        @(negedge clk);
        rst = 1'b0;
        do_cmd(PUSH, 8'h01);
        check("post-reset data_out", 32'(data_out), 32'h01);
        check("post-reset depth", 32'(depth), 32'd1);
        repeat (12) @(posedge clk);
        #1;
        check("no late mul write data_out", 32'(data_out), 32'h01);
        check("no late mul write depth", 32'(depth), 32'd1);

        // wide build: 0xFFFF * 0xFFFF
        do_cmd_w(PUSH, 16'hFFFF);
        do_cmd_w(DUP, 16'h0000);
        check("w dup depth", 32'(w_depth), 32'd2);
        do_cmd_w(MUL, 16'h0000);
        busy = 0;
        while (!w_in_ready && busy < 100) begin
            @(posedge clk); #1;
            busy++;
        end
        check("w mul busy cycles", 32'(busy), 32'd16);
        check("w mul data_out", 32'(w_data_out), 32'h0001);
        check("w mul carry", 32'(w_carry), 32'd1);
        check("w mul depth", 32'(w_depth), 32'd1);
        check("w mul zero", 32'(w_zero), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
